// File: rtl/iir_frame_scheduler.sv
// Frame scheduler for a time-multiplexed IIR biquad datapath: walks every channel and cascade
// stage once per sample-strobe rise, driving MAC, coefficient and state write-back control.
module iir_frame_scheduler #(
   parameter int unsigned N_CH    = 2,
   parameter int unsigned N_STG   = 3,
   parameter int unsigned MAC_LAT = 2,
   parameter int unsigned CH_W    = 1,
   parameter int unsigned STG_W   = 2,
   parameter int unsigned CA_W    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             en,
   input  logic             ovr_clr,
   output logic             in_ld,
   output logic             mac_en,
   output logic             mac_clr,
   output logic [2:0]       tap_sel,
   output logic [CA_W-1:0]  coef_addr,
   output logic [CH_W-1:0]  ch_sel,
   output logic [STG_W-1:0] stg_sel,
   output logic             st_we,
   output logic             out_vld,
   output logic             busy,
   output logic             overrun
);

   typedef enum logic [2:0] {StIdle, StLoad, StMac, StDrain, StWb} state_t;

   localparam logic [CH_W-1:0]  ChLast   = CH_W'(N_CH - 1);
   localparam logic [STG_W-1:0] StgLast  = STG_W'(N_STG - 1);
   localparam logic [2:0]       DrnLast  = 3'(MAC_LAT - 1);
   localparam logic [2:0]       TapLast  = 3'd4;

   state_t     state;
   logic       tick_d;
   logic [2:0] drn_cnt;
   logic       rise;

   assign rise = tick & ~tick_d;

   // Coefficients are laid out five per stage and shared by all channels.
   function automatic logic [CA_W-1:0] coef_of(input logic [STG_W-1:0] s, input logic [2:0] t);
      return CA_W'(s) * CA_W'(5) + CA_W'(t);
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= StIdle;
         tick_d    <= 1'b0;
         drn_cnt   <= 3'd0;
         in_ld     <= 1'b0;
         mac_en    <= 1'b0;
         mac_clr   <= 1'b0;
         tap_sel   <= 3'd0;
         coef_addr <= '0;
         ch_sel    <= '0;
         stg_sel   <= '0;
         st_we     <= 1'b0;
         out_vld   <= 1'b0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         tick_d  <= tick;
         in_ld   <= 1'b0;
         mac_en  <= 1'b0;
         mac_clr <= 1'b0;
         st_we   <= 1'b0;
         out_vld <= 1'b0;

         // A rise during a frame is dropped, not queued; set beats clear.
         if (rise && busy) begin
            overrun <= 1'b1;
         end else if (ovr_clr) begin
            overrun <= 1'b0;
         end

         unique case (state)
            StIdle: begin
               if (rise && en) begin
                  state     <= StLoad;
                  ch_sel    <= '0;
                  stg_sel   <= '0;
                  tap_sel   <= 3'd0;
                  coef_addr <= '0;
                  in_ld     <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            StLoad: begin
               state     <= StMac;
               tap_sel   <= 3'd0;
               coef_addr <= coef_of(stg_sel, 3'd0);
               mac_en    <= 1'b1;
               mac_clr   <= 1'b1;
            end
            StMac: begin
               if (tap_sel == TapLast) begin
                  state   <= StDrain;
                  drn_cnt <= 3'd0;
               end else begin
                  tap_sel   <= tap_sel + 3'd1;
                  coef_addr <= coef_of(stg_sel, tap_sel + 3'd1);
                  mac_en    <= 1'b1;
               end
            end
            StDrain: begin
               if (drn_cnt == DrnLast) begin
                  state   <= StWb;
                  st_we   <= 1'b1;
                  out_vld <= (stg_sel == StgLast);
               end else begin
                  drn_cnt <= drn_cnt + 3'd1;
               end
            end
            StWb: begin
               tap_sel <= 3'd0;
               if (stg_sel != StgLast) begin
                  state     <= StMac;
                  stg_sel   <= stg_sel + STG_W'(1);
                  coef_addr <= coef_of(stg_sel + STG_W'(1), 3'd0);
                  mac_en    <= 1'b1;
                  mac_clr   <= 1'b1;
               end else if (ch_sel != ChLast) begin
                  state     <= StLoad;
                  ch_sel    <= ch_sel + CH_W'(1);
                  stg_sel   <= '0;
                  coef_addr <= '0;
                  in_ld     <= 1'b1;
               end else begin
                  state     <= StIdle;
                  ch_sel    <= '0;
                  stg_sel   <= '0;
                  coef_addr <= '0;
                  busy      <= 1'b0;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_iir_frame_scheduler.sv
// Bench for iir_frame_scheduler: per-cycle frame timeline model, spot-check table and a
// write-back scoreboard fed at each tick rise.
`timescale 1ns/1ps
module tb_iir_frame_scheduler;

   logic       clk, rst, tick, en, ovr_clr;
   logic       in_ld, mac_en, mac_clr, st_we, out_vld, busy, overrun;
   logic [2:0] tap_sel;
   logic [3:0] coef_addr;
   logic [0:0] ch_sel;
   logic [1:0] stg_sel;
   logic [16:0] outs;

   int errs = 0;
   int checks = 0;
   int vld_cnt = 0;

   iir_frame_scheduler dut (
      .clk(clk), .rst(rst), .tick(tick), .en(en), .ovr_clr(ovr_clr),
      .in_ld(in_ld), .mac_en(mac_en), .mac_clr(mac_clr), .tap_sel(tap_sel),
      .coef_addr(coef_addr), .ch_sel(ch_sel), .stg_sel(stg_sel), .st_we(st_we),
      .out_vld(out_vld), .busy(busy), .overrun(overrun)
   );

   assign outs = {in_ld, mac_en, mac_clr, st_we, out_vld, busy, overrun,
                  tap_sel, coef_addr, ch_sel, stg_sel};

   initial begin
      clk = 1'b0;
      forever #50 clk = ~clk;
   end

   initial begin
      #5_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected outputs n cycles after the edge that samples a rise (n=1..50 in frame).
   function automatic logic [16:0] model(input int n, input logic ovr);
      logic il = 0, me = 0, mc = 0, sw = 0, ov = 0, bz = 0;
      int tap = 0, ch = 0, stg = 0, m, p, q;
      if (n >= 1 && n <= 50) begin
         bz = 1;
         ch = (n - 1) / 25;
         m  = (n - 1) % 25;
         if (m == 0) begin
            il = 1;
         end else begin
            p   = m - 1;
            stg = p / 8;
            q   = p % 8;
            if (q < 5) begin
               me  = 1;
               mc  = (q == 0);
               tap = q;
            end else begin
               tap = 4;
               if (q == 7) begin
                  sw = 1;
                  ov = (stg == 2);
               end
            end
         end
      end
      return {il, me, mc, sw, ov, bz, ovr, 3'(tap), 4'(stg * 5 + tap), 1'(ch), 2'(stg)};
   endfunction

   // Write-back scoreboard.
   typedef struct {int ch; int stg; int vld;} wb_t;
   wb_t sb[$];

   task automatic push_frame();
      for (int c = 0; c < 2; c++)
         for (int s = 0; s < 3; s++)
            sb.push_back('{c, s, (s == 2) ? 1 : 0});
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (st_we) begin
            chk("sb pending at st_we", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
               wb_t e;
               e = sb.pop_front();
               chk("sb ch_sel", int'(ch_sel), e.ch);
               chk("sb stg_sel", int'(stg_sel), e.stg);
               chk("sb out_vld", int'(out_vld), e.vld);
            end
         end
         if (out_vld) begin
            chk("out_vld implies st_we", int'(st_we), 1);
            vld_cnt++;
         end
      end
   end

   // Spot-check table of named frame cycles.
   localparam int SigInLd = 0, SigMacClr = 1, SigCoef = 2, SigStWe = 3, SigStg = 4,
                  SigVld = 5, SigCh = 6, SigBusy = 7;
   typedef struct {int n; int sig; int val; string name;} vec_t;
   vec_t tab[$];

   function automatic int get_sig(input int s);
      case (s)
         SigInLd:   return int'(in_ld);
         SigMacClr: return int'(mac_clr);
         SigCoef:   return int'(coef_addr);
         SigStWe:   return int'(st_we);
         SigStg:    return int'(stg_sel);
         SigVld:    return int'(out_vld);
         SigCh:     return int'(ch_sel);
         default:   return int'(busy);
      endcase
   endfunction

   task automatic start_frame(input bit expect_run);
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
      if (expect_run) push_frame();
      tick = 1'b1;
   endtask

   task automatic run_frame_check(input logic ovr);
      start_frame(1'b1);
      for (int n = 1; n <= 51; n++) begin
         @(negedge clk);
         chk($sformatf("frame outs n=%0d", n), int'(outs), int'(model(n, ovr)));
         foreach (tab[i])
            if (tab[i].n == n) chk(tab[i].name, get_sig(tab[i].sig), tab[i].val);
      end
      chk("sb drained", sb.size(), 0);
   endtask

   initial begin
      int v0, bz, il;
      tab.push_back('{1,  SigInLd,   1, "in_ld at k+1"});
      tab.push_back('{1,  SigBusy,   1, "busy at k+1"});
      tab.push_back('{2,  SigMacClr, 1, "mac_clr at k+2"});
      tab.push_back('{3,  SigMacClr, 0, "mac_clr low at k+3"});
      tab.push_back('{2,  SigCoef,   0, "coef k+2"});
      tab.push_back('{3,  SigCoef,   1, "coef k+3"});
      tab.push_back('{4,  SigCoef,   2, "coef k+4"});
      tab.push_back('{5,  SigCoef,   3, "coef k+5"});
      tab.push_back('{6,  SigCoef,   4, "coef k+6"});
      tab.push_back('{9,  SigStWe,   1, "st_we k+9"});
      tab.push_back('{9,  SigStg,    0, "stg k+9"});
      tab.push_back('{17, SigStWe,   1, "st_we k+17"});
      tab.push_back('{17, SigStg,    1, "stg k+17"});
      tab.push_back('{25, SigStg,    2, "stg k+25"});
      tab.push_back('{25, SigVld,    1, "out_vld ch0 k+25"});
      tab.push_back('{25, SigCh,     0, "ch k+25"});
      tab.push_back('{26, SigInLd,   1, "in_ld ch1 k+26"});
      tab.push_back('{50, SigVld,    1, "out_vld ch1 k+50"});
      tab.push_back('{50, SigCh,     1, "ch k+50"});
      tab.push_back('{50, SigBusy,   1, "busy k+50"});
      tab.push_back('{51, SigBusy,   0, "busy low k+51"});

      rst = 1'b0; tick = 1'b0; en = 1'b1; ovr_clr = 1'b0;

      // Reset holds everything at zero while tick toggles.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         tick = ~tick;
         chk("outputs in reset", int'(outs), 0);
      end
      @(negedge clk);
      tick = 1'b0;
      rst  = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle after reset", int'(outs), 0);

      // Single frame, held tick starts only one frame.
      run_frame_check(1'b0);
      bz = 0;
      repeat (20) begin
         @(negedge clk);
         bz += int'(busy);
      end
      chk("held tick no refire", bz, 0);

      // Steady state: 4 real sample periods.
      @(negedge clk);
      tick = 1'b0;
      v0 = vld_cnt;
      for (int p = 0; p < 4; p++) begin
         @(negedge clk);
         push_frame();
         tick = 1'b1;
         repeat (124) @(negedge clk);
         tick = 1'b0;
         repeat (125) @(negedge clk);
      end
      chk("steady out_vld count", vld_cnt - v0, 8);
      chk("steady overrun", int'(overrun), 0);
      chk("steady sb drained", sb.size(), 0);

      // Overrun: second rise 19 edges into the frame.
      start_frame(1'b1);
      for (int n = 1; n <= 51; n++) begin
         @(negedge clk);
         if (n == 10) tick = 1'b0;
         if (n == 19) begin
            chk("overrun before rise", int'(overrun), 0);
            tick = 1'b1;
         end
         if (n == 20) chk("overrun set", int'(overrun), 1);
         if (n == 50) chk("ovr frame out_vld k+50", int'(out_vld), 1);
         if (n == 51) chk("ovr frame done", int'(busy), 0);
      end
      bz = 0;
      repeat (30) begin
         @(negedge clk);
         bz += int'(busy);
      end
      chk("no queued frame", bz, 0);
      chk("overrun sticky", int'(overrun), 1);
      @(negedge clk);
      ovr_clr = 1'b1;
      @(negedge clk);
      ovr_clr = 1'b0;
      chk("overrun cleared", int'(overrun), 0);

      // Set wins over clear in the same cycle.
      start_frame(1'b1);
      for (int n = 1; n <= 51; n++) begin
         @(negedge clk);
         if (n == 5) tick = 1'b0;
         if (n == 9) begin
            tick = 1'b1;
            ovr_clr = 1'b1;
         end
         if (n == 10) begin
            ovr_clr = 1'b0;
            chk("set wins over clr", int'(overrun), 1);
         end
         if (n == 12) ovr_clr = 1'b1;
         if (n == 13) begin
            ovr_clr = 1'b0;
            chk("clr mid frame", int'(overrun), 0);
         end
         if (n == 51) chk("setwins frame done", int'(busy), 0);
      end

      // en=0 at rise is ignored.
      @(negedge clk);
      en = 1'b0;
      start_frame(1'b0);
      il = 0; bz = 0;
      repeat (10) begin
         @(negedge clk);
         il += int'(in_ld);
         bz += int'(busy);
      end
      chk("en=0 no in_ld", il, 0);
      chk("en=0 no busy", bz, 0);
      chk("en=0 no overrun", int'(overrun), 0);

      // en dropped mid-frame: frame completes.
      en = 1'b1;
      v0 = vld_cnt;
      start_frame(1'b1);
      for (int n = 1; n <= 51; n++) begin
         @(negedge clk);
         if (n == 10) en = 1'b0;
         if (n == 51) chk("en drop frame done", int'(busy), 0);
      end
      chk("en drop out_vld count", vld_cnt - v0, 2);
      start_frame(1'b0);
      bz = 0;
      repeat (10) begin
         @(negedge clk);
         bz += int'(busy);
      end
      chk("en low next rise ignored", bz, 0);

      // Reset mid-frame, then a clean full frame.
      en = 1'b1;
      start_frame(1'b1);
      repeat (30) @(negedge clk);
      chk("busy before reset", int'(busy), 1);
      #10 rst = 1'b0;
      #1;
      chk("st_we after async reset", int'(st_we), 0);
      chk("out_vld after async reset", int'(out_vld), 0);
      chk("outs after async reset", int'(outs), 0);
      sb.delete();
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      run_frame_check(1'b0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
